// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin arbiter sharing one square iterator between
// NREQ drawing requesters; streams coloured pixels to the framebuffer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   frame_en              grants allowed only while high
//   abort                 cancel the command in progress
//   req_valid/req_ready   per-requester command handshake
//   req_x0/y0/size/color  packed commands, requester i in slice i
//   it_start/it_rst/it_oe iterator control
//   it_x0/it_y0/it_size   latched command to the iterator
//   it_x/it_y/busy/done   iterator position and status
//   pix_*                 valid/ready pixel stream to the framebuffer
//   busy                  a command is in progress
//   cmd_done/_id/aborted  completion pulse, owner, abort flag
module draw_scheduler #(
  parameter int CORDW = 9,
  parameter int COLRW = 4,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_en,
  input  logic                   abort,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*CORDW-1:0]  req_x0,
  input  logic [NREQ*CORDW-1:0]  req_y0,
  input  logic [NREQ*CORDW-1:0]  req_size,
  input  logic [NREQ*COLRW-1:0]  req_color,
  output logic                   it_start,
  output logic                   it_rst,
  output logic                   it_oe,
  output logic [CORDW-1:0]       it_x0,
  output logic [CORDW-1:0]       it_y0,
  output logic [CORDW-1:0]       it_size,
  input  logic [CORDW-1:0]       it_x,
  input  logic [CORDW-1:0]       it_y,
  input  logic                   it_busy,
  input  logic                   it_done,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [CORDW-1:0]       pix_x,
  output logic [CORDW-1:0]       pix_y,
  output logic [COLRW-1:0]       pix_color,
  output logic                   busy,
  output logic                   cmd_done,
  output logic [IDW-1:0]         cmd_done_id,
  output logic                   cmd_aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_FLUSH,
    S_COMPLETE
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CORDW-1:0] x0_q, x0_d;
  logic [CORDW-1:0] y0_q, y0_d;
  logic [CORDW-1:0] size_q, size_d;
  logic [COLRW-1:0] color_q, color_d;
  logic             busy_q, busy_d;
  logic             abrt_q, abrt_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   cand;

  // Search upward from the requester after the last winner.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(rr_q) + i) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    size_d    = size_q;
    color_d   = color_q;
    busy_d    = busy_q;
    abrt_d    = abrt_q;
    req_ready = '0;
    it_start  = 1'b0;
    it_rst    = 1'b0;
    it_oe     = 1'b0;
    pix_valid = 1'b0;
    cmd_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_en && grant_vld) begin
          req_ready[grant] = 1'b1;
          x0_d    = req_x0[int'(grant)*CORDW +: CORDW];
          y0_d    = req_y0[int'(grant)*CORDW +: CORDW];
          size_d  = req_size[int'(grant)*CORDW +: CORDW];
          color_d = req_color[int'(grant)*COLRW +: COLRW];
          id_d    = grant;
          rr_d    = grant;
          busy_d  = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        it_start = 1'b1;
        // Abort here raises start and reset together; reset wins
        // inside the iterator.
        if (abort) begin
          it_rst  = 1'b1;
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Only it_done ends the run: it_busy may still be low in the
        // first RUN cycle. it_done also beats a same-cycle abort.
        if (it_done) begin
          pix_valid = it_busy;
          it_oe     = pix_ready & it_busy;
          abrt_d    = 1'b0;
          state_d   = S_COMPLETE;
        end else if (abort) begin
          it_rst  = 1'b1;
          state_d = S_FLUSH;
        end else begin
          pix_valid = it_busy;
          it_oe     = pix_ready & it_busy;
        end
      end
      S_FLUSH: begin
        abrt_d  = 1'b1;
        state_d = S_COMPLETE;
      end
      S_COMPLETE: begin
        cmd_done = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= IDW'(NREQ - 1);
      id_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      size_q  <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      size_q  <= size_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      abrt_q  <= abrt_d;
    end
  end

  assign it_x0       = x0_q;
  assign it_y0       = y0_q;
  assign it_size     = size_q;
  assign pix_x       = it_x;
  assign pix_y       = it_y;
  assign pix_color   = color_q;
  assign busy        = busy_q;
  assign cmd_done_id = id_q;
  assign cmd_aborted = abrt_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed bench for draw_scheduler with a behavioural
// square iterator; pixels, grants and completions are logged at negedge.
module tb_draw_scheduler;
  localparam int CORDW = 9;
  localparam int COLRW = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  frame_en;
  logic                  abort;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*CORDW-1:0] req_x0;
  logic [NREQ*CORDW-1:0] req_y0;
  logic [NREQ*CORDW-1:0] req_size;
  logic [NREQ*COLRW-1:0] req_color;
  logic                  it_start;
  logic                  it_rst;
  logic                  it_oe;
  logic [CORDW-1:0]      it_x0;
  logic [CORDW-1:0]      it_y0;
  logic [CORDW-1:0]      it_size;
  logic [CORDW-1:0]      it_x;
  logic [CORDW-1:0]      it_y;
  logic                  it_busy;
  logic                  it_done;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [CORDW-1:0]      pix_x;
  logic [CORDW-1:0]      pix_y;
  logic [COLRW-1:0]      pix_color;
  logic                  busy;
  logic                  cmd_done;
  logic [IDW-1:0]        cmd_done_id;
  logic                  cmd_aborted;

  int errs;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  draw_scheduler #(
    .CORDW(CORDW), .COLRW(COLRW), .NREQ(NREQ), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_en(frame_en), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_size(req_size),
    .req_color(req_color),
    .it_start(it_start), .it_rst(it_rst), .it_oe(it_oe),
    .it_x0(it_x0), .it_y0(it_y0), .it_size(it_size),
    .it_x(it_x), .it_y(it_y), .it_busy(it_busy), .it_done(it_done),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .busy(busy), .cmd_done(cmd_done), .cmd_done_id(cmd_done_id),
    .cmd_aborted(cmd_aborted)
  );

  // Behavioural square iterator: row-major, done one cycle after the
  // last pixel is consumed.
  logic [CORDW-1:0] mx, my, xe, ye;
  logic             mbusy, mdone;
  assign xe      = it_x0 + it_size;
  assign ye      = it_y0 + it_size;
  assign it_x    = mx;
  assign it_y    = my;
  assign it_busy = mbusy;
  assign it_done = mdone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= '0; my <= '0; mbusy <= 1'b0; mdone <= 1'b0;
    end else begin
      mdone <= 1'b0;
      if (it_rst) begin
        mbusy <= 1'b0;
      end else if (it_start) begin
        mx <= it_x0; my <= it_y0; mbusy <= 1'b1;
      end else if (it_oe && mbusy) begin
        if (mx == xe && my == ye) begin
          mbusy <= 1'b0; mdone <= 1'b1;
        end else if (mx == xe) begin
          mx <= it_x0; my <= my + 1'b1;
        end else begin
          mx <= mx + 1'b1;
        end
      end
    end
  end

  logic [31:0] pq[$];
  int          gq[$];
  int          dq[$];
  int          nstart, nrst, oe_bad, multi;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && pix_ready) pq.push_back({10'b0, pix_x, pix_y, pix_color});
      if (it_oe && !pix_ready) oe_bad++;
      if (req_ready != '0) begin
        if ($countones(req_ready) != 1) multi++;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gq.push_back(i);
      end
      if (it_start) nstart++;
      if (it_rst) nrst++;
      if (cmd_done) dq.push_back(int'(cmd_aborted) * 10 + int'(cmd_done_id));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return {10'b0, CORDW'(x), CORDW'(y), COLRW'(c)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    pq.delete(); gq.delete(); dq.delete();
    nstart = 0; nrst = 0; oe_bad = 0;
  endtask

  task automatic set_cmd(input int i, input int x, input int y,
                         input int s, input int c);
    req_x0[i*CORDW +: CORDW]    = CORDW'(x);
    req_y0[i*CORDW +: CORDW]    = CORDW'(y);
    req_size[i*CORDW +: CORDW]  = CORDW'(s);
    req_color[i*COLRW +: COLRW] = COLRW'(c);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && dq.size() == 0; i++) step(1);
    chk(tag, dq.size() != 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    errs = 0; checks = 0; multi = 0;
    clear();
    rst_n = 1'b1; frame_en = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    req_valid = '0; req_x0 = '0; req_y0 = '0; req_size = '0; req_color = '0;
    #3 rst_n = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_start", it_start, 0);
    chk("rst_itrst", it_rst, 0);
    chk("rst_pv", pix_valid, 0);
    chk("rst_id", cmd_done_id, 0);
    chk("rst_abrt", cmd_aborted, 0);
    rst_n = 1'b1;
    step(1);

    // Round robin from reset: pointer at NREQ-1, so 0,1,2,3,0.
    clear();
    for (int i = 0; i < NREQ; i++) set_cmd(i, 100 + i, i, 0, i + 1);
    pix_ready = 1'b1; frame_en = 1'b1; req_valid = '1;
    #1 chk("rr_first", req_ready, 4'b0001);
    for (int i = 0; i < 80 && dq.size() < 5; i++) begin
      step(1);
      if (gq.size() >= 5) req_valid = '0;
    end
    chk("rr_ndone", dq.size(), 5);
    chk("rr_npix", pq.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_grant", gq[k], k % 4);
      chk("rr_pix", pq[k], pk(100 + k % 4, k % 4, k % 4 + 1));
      chk("rr_doneid", dq[k], k % 4);
    end

    // Single command, 2x2 square.
    clear();
    set_cmd(0, 10, 20, 1, 5);
    req_valid = 4'b0001;
    #1 chk("t1_ready", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    chk("t1_start", it_start, 1);
    chk("t1_busy", busy, 1);
    wait_done("t1_done", 40);
    chk("t1_npix", pq.size(), 4);
    chk("t1_p0", pq[0], pk(10, 20, 5));
    chk("t1_p1", pq[1], pk(11, 20, 5));
    chk("t1_p2", pq[2], pk(10, 21, 5));
    chk("t1_p3", pq[3], pk(11, 21, 5));
    chk("t1_dq", dq[0], 0);
    chk("t1_nstart", nstart, 1);
    chk("t1_ngrant", gq.size(), 1);
    chk("t1_idle", busy, 0);

    // Backpressure, 3x3 square.
    clear();
    set_cmd(1, 200, 50, 2, 9);
    req_valid = 4'b0010;
    step(1);
    req_valid = '0;
    for (int i = 0; i < 80 && dq.size() == 0; i++) begin
      pix_ready = ~pix_ready;
      step(1);
    end
    pix_ready = 1'b1;
    chk("bp_done", dq.size() != 0, 1);
    chk("bp_npix", pq.size(), 9);
    for (int k = 0; k < 9; k++)
      chk("bp_pix", pq[k], pk(200 + k % 3, 50 + k / 3, 9));
    chk("bp_oe", oe_bad, 0);
    chk("bp_dq", dq[0], 1);

    // Frame gate.
    clear();
    frame_en = 1'b0;
    req_valid = 4'b0100;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (req_ready != '0 || busy) bad++;
    end
    chk("gate_quiet", bad, 0);
    frame_en = 1'b1;
    #1 chk("gate_ready", req_ready, 4'b0100);
    step(1);
    req_valid = '0;
    wait_done("gate_done", 20);
    chk("gate_gid", gq[0], 2);
    chk("gate_pix", pq[0], pk(102, 2, 3));

    // Abort after 10 pixels of an 8x8 square.
    clear();
    set_cmd(3, 5, 5, 7, 3);
    req_valid = 4'b1000;
    step(1);
    req_valid = '0;
    for (int i = 0; i < 40 && pq.size() < 10; i++) step(1);
    chk("ab_ten", pq.size(), 10);
    chk("ab_p9", pq[9], pk(6, 6, 3));
    abort = 1'b1;
    #1;
    chk("ab_itrst", it_rst, 1);
    chk("ab_pv", pix_valid, 0);
    step(1);
    abort = 1'b0;
    chk("ab_fl_pv", pix_valid, 0);
    chk("ab_fl_done", cmd_done, 0);
    step(1);
    chk("ab_done", cmd_done, 1);
    chk("ab_flag", cmd_aborted, 1);
    chk("ab_id", cmd_done_id, 3);
    step(1);
    chk("ab_npix", pq.size(), 10);
    chk("ab_nrst", nrst, 1);
    chk("ab_busy", busy, 0);
    clear();
    req_valid = 4'b0001;
    #1 chk("ab_next", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    wait_done("ab_next_done", 40);
    chk("ab_next_dq", dq[0], 0);
    chk("ab_next_npix", pq.size(), 4);

    // Asynchronous reset in the middle of a run.
    clear();
    set_cmd(0, 30, 40, 3, 6);
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(4);
    chk("mr_running", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_pv", pix_valid, 0);
    chk("mr_oe", it_oe, 0);
    chk("mr_start", it_start, 0);
    chk("mr_done", cmd_done, 0);
    chk("mr_x0", it_x0, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    clear();
    set_cmd(2, 1, 2, 0, 7);
    req_valid = 4'b0100;
    #1 chk("mr_ready", req_ready, 4'b0100);
    step(1);
    req_valid = '0;
    wait_done("mr_done2", 20);
    chk("mr_npix", pq.size(), 1);
    chk("mr_pix", pq[0], pk(1, 2, 7));
    chk("mr_dq", dq[0], 2);
    chk("onehot", multi, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
